// File: rtl/led_pattern_seq.sv
// Multi-mode LED pattern sequencer: debounced button cycles through OFF/ALTERNATE/CHASE/BLINK,
// and a programmable step counter advances the pattern phase and exports a step tick.
module led_pattern_seq #(
  parameter int         NUM_LEDS        = 4,
  parameter int         STEP_CYCLES     = 16000000,
  parameter int         DEBOUNCE_CYCLES = 160000,
  parameter logic [1:0] INIT_MODE       = 2'd1
) (
  input  logic                WF_CLK,
  input  logic                reset,
  input  logic                WF_BUTTON,
  input  logic                en,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          mode,
  output logic                step_tick
);

  localparam int CNT_W = $clog2(STEP_CYCLES);
  localparam int PH_W  = $clog2(NUM_LEDS);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HALF  = NUM_LEDS / 2;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ALT   = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_BLINK = 2'd3
  } mode_t;

  logic [1:0]          sync_reg;
  logic                db_level_reg, db_level_next;
  logic [DB_W-1:0]     db_cnt_reg, db_cnt_next;
  logic                press;

  mode_t               mode_reg, mode_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [PH_W-1:0]     phase_reg, phase_next, phase_last;
  logic                tick_reg, tick_next;
  logic [NUM_LEDS-1:0] leds_reg, leds_next;
  logic                phase_is_zero;

  // Button path: two-flop synchroniser (idles high = released) feeding the debouncer
  always_ff @(posedge WF_CLK) begin
    if (reset) begin
      sync_reg     <= 2'b11;
      db_level_reg <= 1'b1;
      db_cnt_reg   <= '0;
    end else begin
      sync_reg     <= {sync_reg[0], WF_BUTTON};
      db_level_reg <= db_level_next;
      db_cnt_reg   <= db_cnt_next;
    end
  end

  always_comb begin
    db_level_next = db_level_reg;
    db_cnt_next   = '0;
    press         = 1'b0;
    if (sync_reg[1] != db_level_reg) begin
      if (db_cnt_reg == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level_next = ~db_level_reg;
        press         = db_level_reg;  // only the released->pressed flip counts
      end else begin
        db_cnt_next = db_cnt_reg + DB_W'(1);
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge WF_CLK) begin
    if (reset) begin
      mode_reg  <= mode_t'(INIT_MODE);
      cnt_reg   <= '0;
      phase_reg <= '0;
      tick_reg  <= 1'b0;
      leds_reg  <= '0;
    end else begin
      mode_reg  <= mode_next;
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
      tick_reg  <= tick_next;
      leds_reg  <= leds_next;
    end
  end

  assign phase_last = (mode_reg == MODE_CHASE) ? PH_W'(NUM_LEDS - 1) : PH_W'(1);

  // A press outranks a coincident step wrap: phase restarts and no tick is emitted
  always_comb begin
    mode_next  = mode_reg;
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    tick_next  = 1'b0;
    if (press) begin
      mode_next  = mode_t'(mode_reg + 2'd1);
      cnt_next   = '0;
      phase_next = '0;
    end else if (mode_reg == MODE_OFF) begin
      cnt_next   = '0;
      phase_next = '0;
    end else if (en) begin
      if (cnt_reg == CNT_W'(STEP_CYCLES - 1)) begin
        cnt_next   = '0;
        tick_next  = 1'b1;
        phase_next = (phase_reg == phase_last) ? '0 : phase_reg + PH_W'(1);
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // LED pattern is a pure function of the registered mode and phase
  assign phase_is_zero = (phase_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      assign leds_next[gi] =
          (mode_reg == MODE_ALT)   ? ((gi < HALF) ? phase_is_zero : !phase_is_zero) :
          (mode_reg == MODE_CHASE) ? (phase_reg == PH_W'(gi)) :
          (mode_reg == MODE_BLINK) ? phase_is_zero :
                                     1'b0;
    end
  endgenerate

  assign leds      = leds_reg;
  assign mode      = mode_reg;
  assign step_tick = tick_reg;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: a cycle-level behavioural model pushes expected
// outputs at each rising edge; a monitor pops and compares on the falling edge.
module tb_led_pattern_seq;
  localparam int         N    = 4;
  localparam int         STEP = 8;
  localparam int         DB   = 4;
  localparam logic [1:0] INIT = 2'd1;

  logic         WF_CLK    = 1'b0;
  logic         reset     = 1'b1;
  logic         WF_BUTTON = 1'b1;
  logic         en        = 1'b1;
  logic [N-1:0] leds;
  logic [1:0]   mode;
  logic         step_tick;

  always #5 WF_CLK = ~WF_CLK;

  led_pattern_seq #(
    .NUM_LEDS(N), .STEP_CYCLES(STEP), .DEBOUNCE_CYCLES(DB), .INIT_MODE(INIT)
  ) dut (
    .WF_CLK(WF_CLK), .reset(reset), .WF_BUTTON(WF_BUTTON), .en(en),
    .leds(leds), .mode(mode), .step_tick(step_tick)
  );

  typedef struct packed {
    logic [N-1:0] leds;
    logic [1:0]   mode;
    logic         tick;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: mode, enabled cycles since last restart, accepted button level, raw history
  int m_mode    = INIT;
  int m_elapsed = 0;
  int m_level   = 1;
  int hist[$];

  function automatic int nph(int md);
    return (md == 2) ? N : 2;
  endfunction

  function automatic logic [N-1:0] pat(int md, int ph);
    logic [N-1:0] lo;
    lo = '0;
    for (int i = 0; i < N / 2; i++) lo[i] = 1'b1;
    case (md)
      1:       return (ph == 0) ? lo : (lo << (N / 2));
      2:       return N'(1) << ph;
      3:       return (ph == 0) ? {N{1'b1}} : '0;
      default: return '0;
    endcase
  endfunction

  always @(posedge WF_CLK) begin : model
    exp_t e;
    int   ph_old;
    int   sz;
    bit   all_diff;
    bit   prs;
    ph_old = (m_elapsed / STEP) % nph(m_mode);
    if (reset) begin
      m_mode    = INIT;
      m_elapsed = 0;
      m_level   = 1;
      hist      = {};
      for (int i = 0; i < DB + 2; i++) hist.push_back(1);
      e.leds = '0;
      e.tick = 1'b0;
    end else begin
      e.leds = pat(m_mode, ph_old);
      // The level seen after synchronisation at this edge is the raw sample from two edges ago;
      // a flip needs the last DB such samples all to differ from the accepted level.
      sz = hist.size();
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++)
        if (hist[sz - 2 - j] == m_level) all_diff = 1'b0;
      prs = 1'b0;
      if (all_diff) begin
        prs     = (m_level == 1);
        m_level = 1 - m_level;
      end
      hist.push_back(int'(WF_BUTTON));
      void'(hist.pop_front());
      if (prs) begin
        m_mode    = (m_mode + 1) % 4;
        m_elapsed = 0;
        e.tick    = 1'b0;
      end else if (m_mode != 0 && en) begin
        m_elapsed++;
        e.tick = ((m_elapsed % STEP) == 0);
      end else begin
        e.tick = 1'b0;
      end
    end
    e.mode = 2'(m_mode);
    sb_q.push_back(e);
  end

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  logic [1:0] prev_mode = 2'bxx;

  always @(negedge WF_CLK) begin : monitor
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_underflow", 0, 1);
    end else begin
      e = sb_q.pop_front();
      check("leds", int'(leds), int'(e.leds));
      check("mode", int'(mode), int'(e.mode));
      check("step_tick", int'(step_tick), int'(e.tick));
      if (mode !== prev_mode)
        $display("mode %0d -> %0d at t=%0t (leds=%b)", prev_mode, mode, $time, leds);
      prev_mode = mode;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge WF_CLK);
  endtask

  task automatic press(int n);
    WF_BUTTON = 1'b0;
    cyc(n);
    WF_BUTTON = 1'b1;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    cyc(n);
    reset = 1'b0;
  endtask

  initial begin
    int waited;
    int r;
    // Power-on reset then ALTERNATE stepping
    reset = 1'b1; en = 1'b1; WF_BUTTON = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(40);
    // Long press -> CHASE, single advance
    press(10);
    cyc(50);
    // Short glitch ignored, then three debounced presses cycle back to ALTERNATE
    press(2);
    cyc(20);
    for (int k = 0; k < 3; k++) begin
      press(8);
      cyc(30);
    end
    // CHASE at 0100, freeze with en=0 for 20 cycles
    press(8);
    waited = 0;
    while (leds !== 4'b0100 && waited < 100) begin
      cyc(1);
      waited++;
    end
    if (waited >= 100) check("wait_chase_0100", int'(leds), 4);
    en = 1'b0;
    cyc(20);
    en = 1'b1;
    cyc(30);
    // Press timed across every offset of the step period, including the wrap edge
    for (int d = 0; d < 10; d++) begin
      do_reset(2);
      cyc(d);
      press(6);
      cyc(14);
    end
    // Reset in the middle of BLINK
    do_reset(2);
    press(6);
    cyc(6);
    press(6);
    cyc(13);
    do_reset(1);
    cyc(20);
    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 19);
      if (r < 8)       press($urandom_range(1, 10));
      else if (r < 12) en = ~en;
      else if (r == 12) do_reset($urandom_range(1, 3));
      else             cyc($urandom_range(1, 20));
    end
    en = 1'b1;
    WF_BUTTON = 1'b1;
    cyc(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Parametrised LED pattern sequencer for the RSLK chassis LEDs on the WebFPGA Shasta board.
It generalises the fixed two-state front/back flasher to N LEDs, a programmable step period and four selectable display modes.
The on-board button cycles through the modes, and each press is debounced in-block.
It sits at top level, driving the LED pins directly, and exports a step tick for other blocks to use.

Parameters:
NUM_LEDS, 4, number of LED outputs; must be even and >= 2
STEP_CYCLES, 16000000, clock cycles per pattern step (1 s at 16 MHz); must be >= 2
DEBOUNCE_CYCLES, 160000, cycles the button must be stable before a press is accepted (10 ms)
INIT_MODE, 2'd1, mode loaded at reset

Ports:
WF_CLK  input  1  system clock, 16 MHz
reset  input  1  synchronous, active-high reset
WF_BUTTON  input  1  raw board button, active-low (0 = pressed), asynchronous to WF_CLK
en  input  1  1 = sequencing runs; 0 = freeze step counter, phase and LEDs
leds  output  NUM_LEDS  LED drive, 1 = on, registered
mode  output  2  current mode, registered
step_tick  output  1  one-cycle pulse on each step boundary, registered

Behaviour:
- All state is updated on posedge WF_CLK.
- Reset (synchronous, active-high), values while reset is held:
  - leds = 0, step_tick = 0, mode = INIT_MODE.
  - Step counter = 0, phase = 0.
  - Debounce state = released, synchroniser = 1.
- Reset asserted mid-operation overrides everything on that edge.
- First non-zero LED pattern appears on the first edge after reset deasserts.
- Button path:
  - 2-FF synchroniser into a debounce counter.
  - The counter counts while the synchronised level differs from the debounced level, and clears otherwise.
  - On reaching DEBOUNCE_CYCLES-1 the debounced level flips.
  - A press is the debounced 1->0 transition. It produces exactly one advance: mode <= mode+1, wrapping 3->0.
  - Releases and bounces shorter than DEBOUNCE_CYCLES produce no advance.
  - The button is honoured regardless of en.
- Modes:
  - 0 OFF: leds = 0; step counter and phase held at 0; step_tick = 0.
  - 1 ALTERNATE: phase in {0,1}. Phase 0: lower half leds[NUM_LEDS/2-1:0] = 1, upper half = 0. Phase 1: the reverse.
  - 2 CHASE: phase 0..NUM_LEDS-1; leds = one-hot (1 << phase); wraps from NUM_LEDS-1 to 0.
  - 3 BLINK: phase in {0,1}. Phase 0: all ones. Phase 1: all zeros.
- Step counter (modes 1-3, en = 1):
  - Counts 0..STEP_CYCLES-1, then wraps to 0.
  - On the wrap edge, phase advances (modulo that mode's phase count) and step_tick = 1 for that one cycle.
- en = 0: counter, phase and leds hold their values; step_tick = 0; mode changes are still accepted.
- Mode change on a press edge:
  - Step counter and phase clear to 0 on the same edge; no step_tick is generated.
  - leds show the new mode's phase-0 pattern one cycle later.
- Simultaneous press and step wrap: the mode change wins; phase = 0 and step_tick = 0.
- leds are a registered function of (mode, phase), so the LED pattern lags a phase or mode update by 1 cycle.
- Counter width is $clog2(STEP_CYCLES). The counter never exceeds STEP_CYCLES-1.

Test Plan:
All scenarios use NUM_LEDS=4, STEP_CYCLES=8, DEBOUNCE_CYCLES=4, INIT_MODE=1.
1. Reset for 3 cycles, then release with en=1 -> mode=1.
   - leds=4'b0011 one cycle after release; step_tick pulses every 8 cycles.
   - leds toggle 0011 <-> 1100 on each tick.
2. Hold WF_BUTTON low for 10 cycles, then release -> mode=2.
   - Exactly one advance; leds=0001 next cycle, then 0010, 0100, 1000, 0001 on successive ticks.
3. Glitch WF_BUTTON low for 2 cycles -> no mode change.
   - Then three debounced presses cause mode 2 -> 3 -> 0 -> 1.
   - Mode 3 shows 1111/0000 alternating; mode 0 shows leds=0 with no step_tick.
4. In CHASE at leds=0100, drop en for 20 cycles -> leds stay 0100 and no step_tick.
   - After en returns, the next tick arrives after the remaining counter cycles.
5. Time a debounced press to land on the step-wrap edge -> mode increments, phase=0, step_tick=0 on that cycle.
6. Assert reset mid-step in BLINK -> leds=0 and mode=1 on the following edge.
   - The counter restarts: first tick occurs 8 cycles after reset deasserts.
